// File: rtl/pixel_window_buf.sv
// 3x3 sliding-window builder over a raster pixel stream, two line buffers deep.
// Window appears 1 cycle after its bottom-right pixel is accepted; pixel_ready = !window_valid || window_ready.
module pixel_window_buf #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        pixel_sof,
    output logic        pixel_ready,
    output logic [71:0] in_pixels,
    output logic        window_valid,
    input  logic        window_ready,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       w_col_nxt;
    logic [CW-1:0]       w_cur_col;
    logic [RW-1:0]       r_row;
    logic [RW-1:0]       w_row_nxt;
    logic [RW-1:0]       w_cur_row;

    logic                w_accept;
    logic                w_take;
    logic                w_col_end;
    logic                w_last;
    logic                w_win_load;

    logic [7:0]          r_line_old [IMG_WIDTH];
    logic [7:0]          r_line_new [IMG_WIDTH];
    logic [7:0]          w_old_px;
    logic [7:0]          w_new_px;

    // [row][col][byte]: element [r][c] lands at bits (r*3+c)*8, matching in_pixels.
    logic [2:0][2:0][7:0] r_win;
    logic [2:0][2:0][7:0] w_win_nxt;
    logic [2:0][2:0][7:0] r_out;
    logic                 r_win_vld;
    logic                 r_frame_done;

    assign pixel_ready  = !r_win_vld || window_ready;
    assign window_valid = r_win_vld;
    assign in_pixels    = r_out;
    assign frame_done   = r_frame_done;

    assign w_accept  = pixel_valid && pixel_ready;
    // A sof pixel always restarts at (0,0), whether idle or mid-frame.
    assign w_take    = w_accept && (pixel_sof || (r_state == ST_ACTIVE));
    assign w_cur_col = pixel_sof ? '0 : r_col;
    assign w_cur_row = pixel_sof ? '0 : r_row;
    assign w_col_end = (w_cur_col == CW'(IMG_WIDTH - 1));
    assign w_last    = w_col_end && (w_cur_row == RW'(IMG_HEIGHT - 1));
    assign w_win_load = w_take && (w_cur_row >= RW'(2)) && (w_cur_col >= CW'(2));

    assign w_old_px = r_line_old[w_cur_col];
    assign w_new_px = r_line_new[w_cur_col];

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        if (w_take) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
            end else begin
                w_state_nxt = ST_ACTIVE;
                if (w_col_end) begin
                    w_col_nxt = '0;
                    w_row_nxt = w_cur_row + RW'(1);
                end else begin
                    w_col_nxt = w_cur_col + CW'(1);
                    w_row_nxt = w_cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Oldest line row on top, newest line in the middle, incoming pixel at the bottom.
    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[r][0] = r_win[r][1];
            w_win_nxt[r][1] = r_win[r][2];
        end
        w_win_nxt[0][2] = w_old_px;
        w_win_nxt[1][2] = w_new_px;
        w_win_nxt[2][2] = pixel_in;
    end

    // Line storage is not reset; rows 0 and 1 of each frame overwrite it before any window reads it.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_line_old[w_cur_col] <= w_new_px;
            r_line_new[w_cur_col] <= pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win        <= '0;
            r_out        <= '0;
            r_win_vld    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_take && w_last;
            if (w_take) begin
                r_win <= w_win_nxt;
            end
            if (w_win_load) begin
                r_out     <= w_win_nxt;
                r_win_vld <= 1'b1;
            end else if (window_ready) begin
                r_win_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_window_buf.sv
// Bench for pixel_window_buf at 4x4: vector table, directed corner sequences, randomized gaps vs image model.
module tb_pixel_window_buf;

    localparam int W = 4;
    localparam int H = 4;
    localparam logic [71:0] C0 = 72'h0A0908060504020100;
    localparam logic [71:0] C1 = 72'h0B0A09070605030201;
    localparam logic [71:0] C2 = 72'h0E0D0C0A0908060504;
    localparam logic [71:0] C3 = 72'h0F0E0D0B0A09070605;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_sof;
    logic        pixel_ready;
    logic [71:0] in_pixels;
    logic        window_valid;
    logic        window_ready;
    logic        frame_done;

    always #5 clk = ~clk;

    pixel_window_buf #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_sof    (pixel_sof),
        .pixel_ready  (pixel_ready),
        .in_pixels    (in_pixels),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .frame_done   (frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the frame as a 2D image; a window is cut straight out of it.
    logic [7:0]  img [H][W];
    int          m_row = 0;
    int          m_col = 0;
    bit          m_act = 0;
    logic [71:0] exp_q [$];
    logic [71:0] seen [$];
    int          fd_seen = 0;
    int          fd_exp = 0;
    bit          prev_stall = 0;
    logic [71:0] prev_dat = '0;

    function automatic logic [71:0] win_at(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = img[r-2+i][c-2+j];
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_act = 0;
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {71'd0, window_valid}, 72'd1);
                check("hold_data", in_pixels, prev_dat);
            end
            check("ready_rule", {71'd0, pixel_ready}, {71'd0, (!window_valid || window_ready)});
            if (frame_done) fd_seen++;
            if (window_valid && window_ready) begin
                seen.push_back(in_pixels);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window actual=%h required=none", in_pixels);
                end else begin
                    check("window", in_pixels, exp_q.pop_front());
                end
            end
            prev_stall = window_valid && !window_ready;
            prev_dat   = in_pixels;
            if (pixel_valid && pixel_ready && (pixel_sof || m_act)) begin
                if (pixel_sof) begin
                    m_act = 1;
                    m_row = 0;
                    m_col = 0;
                end
                img[m_row][m_col] = pixel_in;
                if (m_row >= 2 && m_col >= 2) exp_q.push_back(win_at(m_row, m_col));
                if (m_row == H-1 && m_col == W-1) begin
                    m_act = 0;
                    fd_exp++;
                end else if (m_col == W-1) begin
                    m_col = 0;
                    m_row++;
                end else begin
                    m_col++;
                end
            end
        end
    end

    bit rnd_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) window_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] p, input bit sof);
        int n;
        if (rnd_mode) begin
            repeat ($urandom_range(0, 2)) begin
                pixel_valid = 1'b0;
                tick();
            end
        end
        pixel_valid = 1'b1;
        pixel_in    = p;
        pixel_sof   = sof;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pixel_ready) break;
            tick();
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
        tick();
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    task automatic frame(input bit rnd_pix);
        for (int i = 0; i < W*H; i++)
            send(rnd_pix ? 8'($urandom) : 8'(i), i == 0);
    endtask

    task automatic drain();
        rnd_mode     = 0;
        pixel_valid  = 1'b0;
        pixel_sof    = 1'b0;
        window_ready = 1'b1;
        repeat (40) tick();
    endtask

    task automatic expect_ref(input string tag, input int sb, input int fb);
        int n;
        n = seen.size() - sb;
        check({tag, "_nwin"}, 72'(n), 72'd4);
        if (n >= 4) begin
            check({tag, "_w0"}, seen[sb],   C0);
            check({tag, "_w1"}, seen[sb+1], C1);
            check({tag, "_w2"}, seen[sb+2], C2);
            check({tag, "_w3"}, seen[sb+3], C3);
        end
        check({tag, "_fdone"}, 72'(fd_seen - fb), 72'd1);
        check({tag, "_pending"}, 72'(exp_q.size()), 72'd0);
    endtask

    typedef struct {
        logic        vld;
        logic        sof;
        logic [7:0]  pix;
        logic        wr;
        logic        exp_wv;
        logic [71:0] exp_dat;
        logic        exp_fd;
        logic        exp_pr;
    } vec_t;

    vec_t tbl [18];

    task automatic run_table(input string tag);
        for (int k = 0; k < 18; k++) begin
            pixel_valid  = tbl[k].vld;
            pixel_sof    = tbl[k].sof;
            pixel_in     = tbl[k].pix;
            window_ready = tbl[k].wr;
            @(negedge clk);
            check({tag, "_wvalid"}, {71'd0, window_valid}, {71'd0, tbl[k].exp_wv});
            if (tbl[k].exp_wv) check({tag, "_wdata"}, in_pixels, tbl[k].exp_dat);
            check({tag, "_fdone"}, {71'd0, frame_done}, {71'd0, tbl[k].exp_fd});
            check({tag, "_pready"}, {71'd0, pixel_ready}, {71'd0, tbl[k].exp_pr});
            tick();
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    initial begin
        int sb;
        int fb;
        int fe;

        for (int i = 0; i < 18; i++) begin
            tbl[i].vld     = (i < 16);
            tbl[i].sof     = (i == 0);
            tbl[i].pix     = 8'(i);
            tbl[i].wr      = 1'b1;
            tbl[i].exp_wv  = 1'b0;
            tbl[i].exp_dat = '0;
            tbl[i].exp_fd  = 1'b0;
            tbl[i].exp_pr  = 1'b1;
        end
        tbl[11].exp_wv = 1'b1; tbl[11].exp_dat = C0;
        tbl[12].exp_wv = 1'b1; tbl[12].exp_dat = C1;
        tbl[15].exp_wv = 1'b1; tbl[15].exp_dat = C2;
        tbl[16].exp_wv = 1'b1; tbl[16].exp_dat = C3;
        tbl[16].exp_fd = 1'b1;

        rst          = 1'b1;
        pixel_in     = '0;
        pixel_valid  = 1'b0;
        pixel_sof    = 1'b0;
        window_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wvalid", {71'd0, window_valid}, 72'd0);
        check("rst_fdone", {71'd0, frame_done}, 72'd0);
        check("rst_data", in_pixels, 72'd0);
        check("rst_pready", {71'd0, pixel_ready}, 72'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // One gapless frame.
        sb = seen.size(); fb = fd_seen;
        run_table("tbl");
        drain();
        expect_ref("frame", sb, fb);

        // Pixels before any sof are dropped.
        sb = seen.size(); fb = fd_seen;
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
        check("nosof_wvalid", {71'd0, window_valid}, 72'd0);
        run_table("nosof");
        drain();
        expect_ref("nosof", sb, fb);

        // Backpressure from the first window onward.
        sb = seen.size(); fb = fd_seen;
        window_ready = 1'b0;
        for (int i = 0; i <= 10; i++) send(8'(i), i == 0);
        pixel_valid = 1'b1;
        pixel_in    = 8'd11;
        pixel_sof   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pready", {71'd0, pixel_ready}, 72'd0);
            check("stall_wvalid", {71'd0, window_valid}, 72'd1);
            check("stall_data", in_pixels, C0);
            tick();
        end
        window_ready = 1'b1;
        for (int i = 11; i < 16; i++) send(8'(i), 1'b0);
        drain();
        expect_ref("stall", sb, fb);

        // Reset in mid-frame, then a fresh frame.
        for (int i = 0; i <= 9; i++) send(8'(i), i == 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_wvalid", {71'd0, window_valid}, 72'd0);
            check("midrst_fdone", {71'd0, frame_done}, 72'd0);
            check("midrst_pready", {71'd0, pixel_ready}, 72'd1);
            tick();
        end
        rst = 1'b0;
        sb = seen.size(); fb = fd_seen;
        frame(1'b0);
        drain();
        expect_ref("midrst", sb, fb);

        // Sof at pixel 6 aborts the frame in progress.
        sb = seen.size(); fb = fd_seen;
        for (int i = 0; i < 6; i++) send(8'(i), i == 0);
        frame(1'b0);
        drain();
        expect_ref("abort", sb, fb);

        // Random data with random valid/ready gaps over three frames.
        sb = seen.size(); fb = fd_seen; fe = fd_exp;
        rnd_mode = 1;
        for (int f = 0; f < 3; f++) frame(1'b1);
        drain();
        check("rand_nwin", 72'(seen.size() - sb), 72'd12);
        check("rand_fdone", 72'(fd_seen - fb), 72'(fd_exp - fe));
        check("rand_fcount", 72'(fd_seen - fb), 72'd3);
        check("rand_pending", 72'(exp_q.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
